// File: rtl/idct_mac_engine.sv
// -----------------------------------------------------------------------------
// idct_mac_engine
//
// Block-transform engine for the image decompressor. It buffers one N x N
// block of signed samples and multiplies it by the N x N coefficient matrix C,
// which is read through a LANES-wide synchronous ROM port.
//   mode 0 : row pass,    B = A * C    (B[i][j] = sum_k A[i][k] * C[k][j])
//   mode 1 : column pass, B = C^T * A  (B[i][j] = sum_k C[k][i] * A[k][j])
// Each result is arithmetically shifted right by `shift` and then either
// clamped to 0..255 (clip_en = 1) or truncated to OUT_W bits.
//
// Ports
//   Clock, Reset    : rising-edge clock, synchronous active-high reset
//   start           : one-cycle pulse, honoured only in IDLE
//   mode, shift,
//   clip_en         : pass configuration, latched on an accepted start
//   in_valid/in_ready/in_data      : sample stream, row-major A[r][c]
//   coef_addr/coef_data            : coefficient ROM port, LANES lanes;
//                                    data returns one cycle after its address
//   out_valid/out_ready/out_data/out_last : result stream, row-major B[i][j];
//                                    out_last marks B[N-1][N-1]
//   busy            : engine is not IDLE
//   done            : one-cycle pulse after the final output handshake
//   state_dbg       : current FSM state (0 IDLE, 1 LOAD, 2 MAC, 3 EMIT)
//
// Handshake semantics (both streams): a transfer happens on a rising edge
// where valid and ready are both high. in_ready and out_valid are decoded
// from registered state only, and out_data/out_last hold steady while
// out_valid is high and out_ready is low.
// -----------------------------------------------------------------------------
module idct_mac_engine #(
  parameter int N      = 8,
  parameter int LANES  = 2,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  parameter int AW     = 2 * $clog2(N)
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [4:0]              shift,
  input  logic                    clip_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic [LANES*AW-1:0]     coef_addr,
  input  logic [LANES*COEF_W-1:0] coef_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              state_dbg
);

  localparam int LN = $clog2(N);          // bits of one row/column index
  localparam int G  = N / LANES;          // issue groups per element
  localparam int GW = $clog2(G + 1);      // group counter runs 0..G
  localparam int PW = DATA_W + COEF_W;    // exact product width

  localparam logic [GW-1:0]           G_LAST   = GW'(G);
  localparam logic [LN-1:0]           IDX_MAX  = LN'(N - 1);
  localparam logic [AW-1:0]           CNT_LAST = AW'(N * N - 1);
  localparam logic signed [ACC_W-1:0] CLIP_MAX = ACC_W'(255);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MAC  = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Latched pass configuration
  logic       mode_q;
  logic [4:0] shift_q;
  logic       clip_q;

  // Counters
  logic [AW-1:0] cnt_q;         // sample write index during LOAD
  logic [LN-1:0] i_q;           // output row
  logic [LN-1:0] j_q;           // output column
  logic [GW-1:0] g_q;           // MAC group

  // Datapath
  logic [DATA_W-1:0]        blk_mem [N*N];
  logic [LN-1:0]            k_idx   [LANES];
  logic signed [DATA_W-1:0] op_d    [LANES];
  logic signed [DATA_W-1:0] op_q    [LANES];
  logic signed [COEF_W-1:0] coef_l  [LANES];
  logic signed [PW-1:0]     prod    [LANES];
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  grp_sum;
  logic signed [ACC_W-1:0]  sum_full;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W+OUT_W-1:0] shifted_ext;
  logic [OUT_W-1:0]         result;
  logic                     issue;

  logic [OUT_W-1:0] out_data_q;
  logic             out_last_q;
  logic             done_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // A start in the same cycle as the done pulse is dropped so that a
  // back-to-back start is taken only from the cycle after done.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && !done_q)                  state_d = S_LOAD;
      S_LOAD: if (in_valid && (cnt_q == CNT_LAST))   state_d = S_MAC;
      S_MAC:  if (g_q == G_LAST)                     state_d = S_EMIT;
      S_EMIT: if (out_ready)                         state_d = out_last_q ? S_IDLE : S_MAC;
      default:                                       state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == S_LOAD);
    out_valid = (state_q == S_EMIT);
    busy      = (state_q != S_IDLE);
    state_dbg = state_q;
  end

  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign done     = done_q;

  // ---------------------------------------------------------------------------
  // Address / operand generation.
  // In issue cycles (MAC with g < G) lane l handles k = g*LANES + l. The
  // operand is captured into op_q on the same edge the ROM captures the
  // address, so op_q and coef_data line up in the following cycle.
  // Since N is a power of two, k*N + x is simply {k, x}.
  // ---------------------------------------------------------------------------
  always_comb begin
    issue     = (state_q == S_MAC) && (g_q != G_LAST);
    coef_addr = '0;
    for (int l = 0; l < LANES; l++) begin
      k_idx[l] = LN'(int'(g_q) * LANES + l);
      op_d[l]  = '0;
      if (issue) begin
        if (!mode_q) begin
          coef_addr[l*AW +: AW] = {k_idx[l], j_q};
          op_d[l]               = blk_mem[{i_q, k_idx[l]}];
        end else begin
          coef_addr[l*AW +: AW] = {k_idx[l], i_q};
          op_d[l]               = blk_mem[{k_idx[l], j_q}];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lane products, group sum and result formatting.
  // Operands are sign-extended to the full product width so the PW-bit
  // multiply is exact; products are then sign-extended into the accumulator.
  // ---------------------------------------------------------------------------
  always_comb begin
    grp_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      coef_l[l] = $signed(coef_data[l*COEF_W +: COEF_W]);
      prod[l]   = $signed({{COEF_W{op_q[l][DATA_W-1]}}, op_q[l]}) *
                  $signed({{DATA_W{coef_l[l][COEF_W-1]}}, coef_l[l]});
      grp_sum   = grp_sum + $signed({{(ACC_W-PW){prod[l][PW-1]}}, prod[l]});
    end
    sum_full    = acc_q + grp_sum;
    shifted     = sum_full >>> shift_q;
    shifted_ext = $signed({{OUT_W{shifted[ACC_W-1]}}, shifted});
    result      = shifted_ext[OUT_W-1:0];
    if (clip_q) begin
      if (shifted[ACC_W-1]) begin
        result = '0;
      end else if (shifted > CLIP_MAX) begin
        result = OUT_W'(255);
      end else begin
        result = shifted_ext[OUT_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Block buffer: holds A; no reset, written only while loading.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Reset && (state_q == S_LOAD) && in_valid) begin
      blk_mem[cnt_q] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control counters, accumulator and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mode_q     <= 1'b0;
      shift_q    <= '0;
      clip_q     <= 1'b0;
      cnt_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      g_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        op_q[l] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !done_q) begin
            mode_q  <= mode;
            shift_q <= shift;
            clip_q  <= clip_en;
            cnt_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            g_q     <= '0;
          end
        end

        S_LOAD: begin
          if (in_valid) begin
            cnt_q <= cnt_q + AW'(1);
          end
        end

        S_MAC: begin
          for (int l = 0; l < LANES; l++) begin
            op_q[l] <= op_d[l];
          end
          // g = 0 only issues; from g = 1 the ROM data of group g-1 is present.
          if (g_q == '0) begin
            acc_q <= '0;
          end else begin
            acc_q <= sum_full;
          end
          if (g_q == G_LAST) begin
            out_data_q <= result;
            out_last_q <= (i_q == IDX_MAX) && (j_q == IDX_MAX);
            g_q        <= '0;
          end else begin
            g_q <= g_q + GW'(1);
          end
        end

        S_EMIT: begin
          if (out_ready) begin
            out_last_q <= 1'b0;
            if (out_last_q) begin
              done_q <= 1'b1;
            end else if (j_q == IDX_MAX) begin
              j_q <= '0;
              i_q <= i_q + LN'(1);
            end else begin
              j_q <= j_q + LN'(1);
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule
